// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cache_pkg
// Brief   : Shared widths, refill FSM state encoding and one-hot check for
//           the 4-way fully associative cache miss path.
// Revision: 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int WAYS   = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        FILL = 2'd3
    } refill_state_t;

    function automatic logic is_onehot(input logic [WAYS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_cnt.sv
`default_nettype none
// ============================================================================
// Module  : mem_wait_cnt
// Brief   : Loadable down-counter with zero flag; times RAM access states.
// Revision: 1.0 - initial release
// ============================================================================
module mem_wait_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cache_refill_ctrl
// Brief   : Miss-handling FSM: optional dirty-victim writeback, RAM read,
//           then one-cycle fill of the victim way. CACHE_WB_EN selects the
//           write-back variant; undefined gives a write-through cache.
// Revision: 1.0 - initial release
// ============================================================================
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic [WAYS-1:0]   lru,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_tag,
    input  logic [DATA_W-1:0] victim_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [WAYS-1:0]   fill_we,
    output logic [ADDR_W-1:0] fill_tag,
    output logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W-1:0] c_wait_load = CNT_W'(MEM_LAT - 1);

    refill_state_t     r_state;
    refill_state_t     w_next;
    logic [ADDR_W-1:0] r_miss_addr;
    logic [WAYS-1:0]   r_lru;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_err;
    logic              w_accept;
    logic              w_take_wb;
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic              w_cnt_zero;

    assign w_accept = (r_state == IDLE) && miss_req && is_onehot(lru);

`ifdef CACHE_WB_EN
    logic [ADDR_W-1:0] r_victim_tag;
    logic [DATA_W-1:0] r_victim_data;

    assign w_take_wb = victim_dirty;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_victim_tag  <= '0;
            r_victim_data <= '0;
        end else if (w_accept) begin
            r_victim_tag  <= victim_tag;
            r_victim_data <= victim_data;
        end
    end
`else
    logic w_unused_victim;

    assign w_take_wb       = 1'b0;
    assign w_unused_victim = ^{victim_dirty, victim_tag, victim_data};
`endif

    mem_wait_cnt #(
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (w_cnt_load),
        .load_val (c_wait_load),
        .dec      (w_cnt_dec),
        .zero     (w_cnt_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_miss_addr <= '0;
            r_lru       <= '0;
            r_rd_data   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= (r_state == IDLE) && miss_req && !is_onehot(lru);
            if (w_accept) begin
                r_miss_addr <= miss_addr;
                r_lru       <= lru;
            end
            // RAM data is only guaranteed on the final read cycle
            if ((r_state == RD) && w_cnt_zero) begin
                r_rd_data <= mem_rd_data;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_address = '0;
        mem_wr_data = '0;
        fill_we     = '0;
        fill_tag    = '0;
        fill_data   = '0;
        done        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next     = w_take_wb ? WB : RD;
                    w_cnt_load = 1'b1;
                end
            end
`ifdef CACHE_WB_EN
            WB: begin
                mem_wr_en   = 1'b1;
                mem_address = r_victim_tag;
                mem_wr_data = r_victim_data;
                if (w_cnt_zero) begin
                    w_next     = RD;
                    w_cnt_load = 1'b1;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
`endif
            RD: begin
                mem_rd_en   = 1'b1;
                mem_address = r_miss_addr;
                if (w_cnt_zero) begin
                    w_next = FILL;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            FILL: begin
                fill_we   = r_lru;
                fill_tag  = r_miss_addr;
                fill_data = r_rd_data;
                done      = 1'b1;
                w_next    = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign busy = (r_state != IDLE);
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cache_refill_ctrl
// Brief   : Directed vector table plus hand sequences for cache_refill_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cache_refill_ctrl;
    import cache_pkg::*;

    localparam int MEM_LAT = 2;
    localparam int WINDOW  = 2 * MEM_LAT + 5;
`ifdef CACHE_WB_EN
    localparam bit WB_ON = 1'b1;
`else
    localparam bit WB_ON = 1'b0;
`endif

    typedef struct {
        logic [WAYS-1:0]   lru;
        logic              dirty;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] vtag;
        logic [DATA_W-1:0] vdata;
        logic [DATA_W-1:0] rdat;
        logic              exp_err;
    } vec_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              miss_req = 1'b0;
    logic [ADDR_W-1:0] miss_addr = '0;
    logic [WAYS-1:0]   lru = '0;
    logic              victim_dirty = 1'b0;
    logic [ADDR_W-1:0] victim_tag = '0;
    logic [DATA_W-1:0] victim_data = '0;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wr_data;
    logic [WAYS-1:0]   fill_we;
    logic [ADDR_W-1:0] fill_tag;
    logic [DATA_W-1:0] fill_data;
    logic              busy;
    logic              done;
    logic              err;

    logic [DATA_W-1:0] ram [2**ADDR_W];
    int total = 0;
    int bad   = 0;

    assign mem_rd_data = mem_rd_en ? ram[mem_address] : '0;

    always #5 clock = ~clock;

    cache_refill_ctrl #(
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .miss_req     (miss_req),
        .miss_addr    (miss_addr),
        .lru          (lru),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .victim_data  (victim_data),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .mem_address  (mem_address),
        .mem_wr_data  (mem_wr_data),
        .fill_we      (fill_we),
        .fill_tag     (fill_tag),
        .fill_data    (fill_data),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({mem_rd_en, mem_wr_en, mem_address, mem_wr_data, fill_we,
                    fill_tag, fill_data, busy, done, err} != '0);
    endfunction

    // Issue one request from posedge+1, observe a fixed window, return at posedge+1.
    task automatic run_vec(input int idx, input vec_t v);
        int lat = 0, dn = 0, wr = 0, rd = 0, both = 0, badaddr = 0;
        int errs = 0, errcyc = 0, busyc = 0, stray = 0, exp_lat;
        logic [WAYS-1:0]   fwe = '0;
        logic [ADDR_W-1:0] ftag = '0;
        logic [DATA_W-1:0] fdat = '0;
        bit                wb_exp;
        wb_exp  = !v.exp_err && v.dirty && WB_ON;
        exp_lat = v.exp_err ? 0 : (wb_exp ? 2 * MEM_LAT + 1 : MEM_LAT + 1);
        ram[v.addr]  = v.rdat;
        miss_addr    = v.addr;
        lru          = v.lru;
        victim_dirty = v.dirty;
        victim_tag   = v.vtag;
        victim_data  = v.vdata;
        miss_req     = 1'b1;
        @(posedge clock); #1;
        miss_req = 1'b0;
        for (int k = 1; k <= WINDOW; k++) begin
            @(negedge clock);
            if (mem_wr_en && mem_rd_en) both++;
            if (mem_wr_en) begin
                wr++;
                if (mem_address !== v.vtag || mem_wr_data !== v.vdata) badaddr++;
            end
            if (mem_rd_en) begin
                rd++;
                if (mem_address !== v.addr) badaddr++;
            end
            if (err) begin
                errs++;
                errcyc = k;
            end
            if (busy) busyc++;
            if (!done && fill_we != '0) stray++;
            if (done) begin
                dn++;
                if (lat == 0) begin
                    lat  = k;
                    fwe  = fill_we;
                    ftag = fill_tag;
                    fdat = fill_data;
                end
            end
            @(posedge clock); #1;
        end
        check($sformatf("v%0d latency", idx), lat, exp_lat);
        check($sformatf("v%0d done_count", idx), dn, v.exp_err ? 0 : 1);
        check($sformatf("v%0d wr_cycles", idx), wr, wb_exp ? MEM_LAT : 0);
        check($sformatf("v%0d rd_cycles", idx), rd, v.exp_err ? 0 : MEM_LAT);
        check($sformatf("v%0d bad_addr_data", idx), badaddr, 0);
        check($sformatf("v%0d rd_wr_overlap", idx), both, 0);
        check($sformatf("v%0d stray_fill_we", idx), stray, 0);
        check($sformatf("v%0d err_count", idx), errs, v.exp_err ? 1 : 0);
        check($sformatf("v%0d busy_cycles", idx), busyc, exp_lat);
        if (v.exp_err) begin
            check($sformatf("v%0d err_cycle", idx), errcyc, 1);
        end else begin
            check($sformatf("v%0d fill_we", idx), fwe, v.lru);
            check($sformatf("v%0d fill_tag", idx), ftag, v.addr);
            check($sformatf("v%0d fill_data", idx), fdat, v.rdat);
        end
    endtask

    initial begin
        vec_t vecs [6];
        vec_t fresh;
        int   dn, busyc, errs;
        //            lru      dirty  addr    vtag    vdata   rdat    err
        vecs[0] = '{4'b0100, 1'b0, 7'h15, 7'h00, 8'h00, 8'hA5, 1'b0};
        vecs[1] = '{4'b0001, 1'b1, 7'h33, 7'h20, 8'h3C, 8'h5A, 1'b0};
        vecs[2] = '{4'b0110, 1'b0, 7'h10, 7'h00, 8'h00, 8'h11, 1'b1};
        vecs[3] = '{4'b0000, 1'b1, 7'h12, 7'h05, 8'h66, 8'h22, 1'b1};
        vecs[4] = '{4'b1000, 1'b0, 7'h7F, 7'h01, 8'h02, 8'hFF, 1'b0};
        vecs[5] = '{4'b0010, 1'b1, 7'h00, 7'h7F, 8'h81, 8'h01, 1'b0};
        for (int i = 0; i < 2**ADDR_W; i++) ram[i] = '0;

        @(negedge clock);
        check("reset_outputs_zero", all_outs(), 0);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Requests during RD and during FILL must be dropped.
        ram[7'h11] = 8'h22;
        ram[7'h44] = 8'h77;
        miss_addr = 7'h11; lru = 4'b0100; victim_dirty = 1'b0; miss_req = 1'b1;
        @(posedge clock); #1;
        miss_addr = 7'h44; lru = 4'b0001;
        @(posedge clock); #1;
        miss_req = 1'b0;
        @(posedge clock); #1;
        miss_req = 1'b1;
        @(negedge clock);
        check("busy_fill_done", done, 1);
        check("busy_fill_tag", fill_tag, 7'h11);
        check("busy_fill_data", fill_data, 8'h22);
        @(posedge clock); #1;
        miss_req = 1'b0;
        dn = 0; busyc = 0; errs = 0;
        for (int k = 0; k < WINDOW; k++) begin
            @(negedge clock);
            if (done) dn++;
            if (busy) busyc++;
            if (err) errs++;
            @(posedge clock); #1;
        end
        check("busy_extra_done", dn, 0);
        check("busy_extra_busy", busyc, 0);
        check("busy_extra_err", errs, 0);

        // Reset in the middle of RD aborts with no fill.
        ram[7'h2A] = 8'h99;
        miss_addr = 7'h2A; lru = 4'b0010; victim_dirty = 1'b0; miss_req = 1'b1;
        @(posedge clock); #1;
        miss_req = 1'b0;
        @(negedge clock);
        check("midrd_rd_en", mem_rd_en, 1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("midrd_reset_outputs_zero", all_outs(), 0);
        dn = 0; busyc = 0;
        for (int k = 0; k < WINDOW; k++) begin
            @(negedge clock);
            if (done || fill_we != '0) dn++;
            if (busy) busyc++;
        end
        @(posedge clock); #1;
        check("midrd_no_fill", dn, 0);
        check("midrd_idle", busyc, 0);
        fresh = '{4'b1000, 1'b0, 7'h2B, 7'h00, 8'h00, 8'hC3, 1'b0};
        run_vec(6, fresh);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
